// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured bit pattern MSB-first a given
// number of times, with a fixed number of idle cycles between copies.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [PAT_W-1:0] pat_reg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] copies;
  logic [CNT_W-1:0] gap_reg;
  logic [CNT_W-1:0] gap_cnt;

  // copies counts down to 1, never through 0, so the maximum repeat cannot wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat_reg <= '0;
      idx     <= '0;
      copies  <= '0;
      gap_reg <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort && (repeat_n != '0)) begin
            pat_reg <= pattern;
            copies  <= repeat_n;
            gap_reg <= gap;
            idx     <= LAST_IDX;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else if (idx == '0) begin
            copies <= copies - 1'b1;
            if (copies == CNT_W'(1)) begin
              state <= DONE;
            end else if (gap_reg != '0) begin
              gap_cnt <= gap_reg;
              state   <= GAP;
            end else begin
              idx <= LAST_IDX;
            end
          end else begin
            idx <= idx - 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
          end else if (gap_cnt == CNT_W'(1)) begin
            idx   <= LAST_IDX;
            state <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out       = (state == SHIFT) & pat_reg[idx];
  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT) || (state == GAP);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized self-checking bench for seq_pattern_tx; expected per-cycle
// outputs come from a burst model built directly from pattern/repeat/gap.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [CNT_W-1:0] gap;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  int tests_run    = 0;
  int tests_failed = 0;

  // each entry is the expected {out, out_valid, busy, done} for one cycle
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap      (gap),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {out, out_valid, busy, done};
  endfunction

  // burst = rep copies of the pattern, gap idles between copies, one done cycle
  task automatic build_expected(input logic [PAT_W-1:0] p, input int rep, input int g);
    exp_q.delete();
    for (int c = 0; c < rep; c++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
      if (c < rep - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
    end
    if (rep > 0) exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic launch(input logic [PAT_W-1:0] p, input int rep, input int g);
    pattern  = p;
    repeat_n = CNT_W'(rep);
    gap      = CNT_W'(g);
    start    = 1'b1;
    abort    = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    pattern = 4'b1001; repeat_n = 4'd3; gap = 4'd1;
    tick();
    tick();
    tests_run++;
    if (obs() !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got %b expected 0000", obs());
    end
    rst = 1'b0; start = 1'b0;
    tick();
    tests_run++;
    if (obs() !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %b expected 0000", obs());
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    build_expected(4'b1001, 1, 0);
    launch(4'b1001, 1, 0);
    foreach (exp_q[i]) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL single cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    tests_run++;
    if (busy_cnt !== 4) begin
      tests_failed++;
      $display("[TB] FAIL single_busy: got %0d expected 4", busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] sh = 4'b0000;
    int hits = 0;
    build_expected(4'b1001, 2, 0);
    launch(4'b1001, 2, 0);
    foreach (exp_q[i]) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL b2b cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      if (out_valid === 1'b1) begin
        sh = {sh[2:0], out};
        if (sh == 4'b1001) hits++;
      end
      tick();
    end
    tests_run++;
    if (hits !== 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_detector: got %0d hits expected 2", hits);
    end
  endtask

  task automatic test_gap();
    int busy_cnt = 0;
    build_expected(4'b1001, 3, 2);
    launch(4'b1001, 3, 2);
    foreach (exp_q[i]) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL gap cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      if (busy === 1'b1) busy_cnt++;
      abort = (i == exp_q.size() - 2);
      tick();
    end
    abort = 1'b0;
    tests_run++;
    if (busy_cnt !== 16) begin
      tests_failed++;
      $display("[TB] FAIL gap_busy: got %0d expected 16", busy_cnt);
    end
  endtask

  task automatic test_repeat_zero();
    launch(4'b1011, 0, 2);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs() !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL repeat_zero cycle %0d: got %b expected 0000", i, obs());
      end
      tick();
    end
  endtask

  task automatic test_start_mid_burst();
    logic [PAT_W-1:0] p = PAT_W'($urandom);
    build_expected(p, 2, 1);
    launch(p, 2, 1);
    foreach (exp_q[i]) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL start_mid cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      start    = (i == 2) || (i == 4) || (i == exp_q.size() - 2);
      pattern  = ~p;
      repeat_n = 4'd5;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    build_expected(4'b1101, 2, 0);
    launch(4'b1101, 2, 0);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL abort_pre cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      abort = (i == 1);
      tick();
    end
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs() !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL abort_post cycle %0d: got %b expected 0000", i, obs());
      end
      tick();
    end
    // abort in GAP as well
    build_expected(4'b0111, 3, 3);
    launch(4'b0111, 3, 3);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL abort_gap_pre cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      abort = (i == 5);
      tick();
    end
    abort = 1'b0;
    tests_run++;
    if (obs() !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL abort_gap_post: got %b expected 0000", obs());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    build_expected(4'b1001, 3, 1);
    launch(4'b1001, 3, 1);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL rst_mid_pre cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      rst = (i == 2);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs() !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL rst_mid_post cycle %0d: got %b expected 0000", i, obs());
      end
      tick();
    end
  endtask

  task automatic test_abort_start_idle();
    pattern = 4'b1111; repeat_n = 4'd3; gap = 4'd0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs() !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL abort_start cycle %0d: got %b expected 0000", i, obs());
      end
      tick();
    end
  endtask

  task automatic test_capture();
    build_expected(4'b1001, 2, 1);
    launch(4'b1001, 2, 1);
    pattern = 4'b0110; repeat_n = 4'd7; gap = 4'd5;
    foreach (exp_q[i]) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL capture cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_max();
    logic [PAT_W-1:0] p = PAT_W'($urandom);
    int busy_cnt = 0;
    int rep = (1 << CNT_W) - 1;
    build_expected(p, rep, rep);
    launch(p, rep, rep);
    foreach (exp_q[i]) begin
      if (obs() !== exp_q[i]) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL max cycle %0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    tests_run++;
    if (busy_cnt !== rep * PAT_W + (rep - 1) * rep) begin
      tests_failed++;
      $display("[TB] FAIL max_busy: got %0d expected %0d", busy_cnt, rep * PAT_W + (rep - 1) * rep);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [PAT_W-1:0] p = PAT_W'($urandom);
      int rep = $urandom_range(0, 5);
      int g   = $urandom_range(0, 4);
      int errs = 0;
      build_expected(p, rep, g);
      launch(p, rep, g);
      foreach (exp_q[i]) begin
        if (obs() !== exp_q[i]) begin
          errs++;
          $display("[TB] FAIL random burst %0d cycle %0d: got %b expected %b", n, i, obs(), exp_q[i]);
        end
        start    = (i < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
        pattern  = PAT_W'($urandom);
        repeat_n = CNT_W'($urandom);
        gap      = CNT_W'($urandom);
        tick();
      end
      start = 1'b0;
      tests_run++;
      if (errs != 0) tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_repeat_zero();
    test_start_mid_burst();
    test_abort();
    test_reset_mid();
    test_abort_start_idle();
    test_capture();
    test_max();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the repeat and gap counts.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a transmission burst.
REQ-006 SHALL have port abort  input  1  request to terminate the current burst.
REQ-007 SHALL have port pattern  input  PAT_W  bit pattern to send, MSB first; 4'b1001 is the nominal value.
REQ-008 SHALL have port repeat  input  CNT_W  number of pattern copies per burst.
REQ-009 SHALL have port gap  input  CNT_W  number of idle cycles between copies.
REQ-010 SHALL have port out  output  1  serial data bit.
REQ-011 SHALL have port out_valid  output  1  out carries a pattern bit this cycle.
REQ-012 SHALL have port busy  output  1  burst in progress.
REQ-013 SHALL have port done  output  1  single-cycle burst-complete pulse.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, SHIFT, GAP and DONE; all outputs SHALL be functions of registered state only.
REQ-015 IDLE outputs SHALL be: out=0, out_valid=0, busy=0, done=0.
REQ-016 In IDLE, start=1 with abort=0 and repeat!=0 SHALL capture pattern, repeat and gap into internal registers, set bit index to PAT_W-1, and enter SHIFT at the same edge.
REQ-017 In IDLE, start=1 with repeat==0 SHALL be ignored: no capture, no done, state stays IDLE.
REQ-018 SHIFT outputs SHALL be: out=pattern_reg[index], out_valid=1, busy=1; index SHALL decrement by one per cycle.
REQ-019 SHIFT SHALL handle the last bit (index==0) as follows:
- if copies remaining >1 and gap_reg!=0, enter GAP with gap counter = gap_reg;
- if copies remaining >1 and gap_reg==0, stay in SHIFT with index = PAT_W-1 (back-to-back, no bubble);
- if copies remaining ==1, enter DONE.
- In every case the remaining-copy count SHALL decrement by one.
REQ-020 GAP outputs SHALL be: out=0, out_valid=0, busy=1; GAP SHALL last exactly gap_reg cycles, then enter SHIFT with index=PAT_W-1.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=0, out_valid=0, out=0, then enter IDLE.
REQ-022 Total busy cycles per burst SHALL equal repeat*PAT_W + (repeat-1)*gap.
REQ-023 The first valid bit SHALL appear in the cycle following the edge at which start is accepted.
REQ-024 start asserted in SHIFT, GAP or DONE SHALL be ignored; it is not queued.
REQ-025 Changes on pattern, repeat or gap after capture SHALL NOT affect the burst in progress.
REQ-026 abort=1 in SHIFT or GAP SHALL force IDLE at the next edge with no done pulse.
REQ-027 abort=1 in DONE SHALL have no effect; the done pulse still occurs.
REQ-028 abort=1 together with start=1 in IDLE SHALL leave the block in IDLE; abort wins.
REQ-029 Maximum repeat (2^CNT_W-1) and maximum gap SHALL be handled without counter wrap-around errors.

Reset
REQ-030 rst=1 SHALL, at the next rising edge, force IDLE and clear the index, copy count, gap count and captured registers to 0, giving out=0, out_valid=0, busy=0, done=0.
REQ-031 rst SHALL take priority over start and abort.
REQ-032 rst asserted mid-burst SHALL terminate the burst with no done pulse.
REQ-033 Any undefined state encoding SHALL return to IDLE at the next edge.

Verification
REQ-034 start, pattern=1001, repeat=1, gap=0 -> out_valid high for 4 cycles carrying 1,0,0,1, then done=1 for 1 cycle, then IDLE; busy high for exactly 4 cycles.
REQ-035 pattern=1001, repeat=2, gap=0 -> 8 contiguous valid bits 10011001, done in cycle 9; an overlapping 1001 Moore detector on out reports 2 hits.
REQ-036 pattern=1001, repeat=3, gap=2 -> valid pattern, 2 idle cycles, valid pattern, 2 idle cycles, valid pattern; 16 busy cycles, then done.
REQ-037 Burst with repeat=0; start pulsed mid-burst -> repeat=0 start leaves the block in IDLE with busy=0 and no done; the mid-burst start has no effect on bit order or length.
REQ-038 abort in cycle 2 of a repeat=2 burst; rst in cycle 3 of another burst -> each returns to IDLE at the next edge with all outputs 0 and no done pulse.
REQ-039 pattern and repeat changed on the cycle after start -> transmitted bits match the values captured at start.
